// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_arb_pkg;

  localparam int unsigned RD_W = 5;
  localparam int unsigned DW   = 64;

  localparam logic [RD_W-1:0] REG_X0 = '0;

  // One buffered long-latency result.
  typedef struct packed {
    logic            valid;
    logic            killed;
    logic [RD_W-1:0] rd;
    logic [DW-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// Pending-result storage: circular buffer with a kill-by-address broadcast
// and a parallel destination match for the hazard query.
module wb_pending_fifo
  import wb_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [RD_W-1:0]  push_rd_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  input  logic             kill_en_i,
  input  logic [RD_W-1:0]  kill_addr_i,
  input  logic [RD_W-1:0]  chk_addr_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             chk_hit_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] killed_q;
  logic [RD_W-1:0]  rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_kill;
  logic             hit;

  // A result arriving in the same cycle as a younger pipe write to its rd is dead on arrival.
  assign push_kill = kill_en_i && (push_rd_i == kill_addr_i);

  // Entry flags: kill broadcast, pop clears the head, push fills the tail.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      killed_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && valid_q[i] && (rd_q[i] == kill_addr_i)) killed_q[i] <= 1'b1;
      end
      if (pop_i) valid_q[rd_ptr_q] <= 1'b0;
      if (push_i) begin
        valid_q[wr_ptr_q]  <= 1'b1;
        killed_q[wr_ptr_q] <= push_kill;
      end
    end
  end

  // Payload is only meaningful under a set valid flag, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Parallel match of all live entries against the hazard query address.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !killed_q[i] && (rd_q[i] == chk_addr_i)) hit = 1'b1;
    end
  end

  assign chk_hit_o = (chk_addr_i != REG_X0) && hit;

  assign head_o.valid  = valid_q[rd_ptr_q];
  assign head_o.killed = killed_q[rd_ptr_q];
  assign head_o.rd     = rd_q[rd_ptr_q];
  assign head_o.data   = data_q[rd_ptr_q];
  assign count_o       = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order write-back stage
// and buffered long-latency results; forces a stall when the buffer head
// starves or the buffer fills.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_pipe_we,
  input  logic [REG_ADDR_W-1:0] i_pipe_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_pipe_result,
  input  logic                  i_mc_valid,
  output logic                  o_mc_ready,
  input  logic [REG_ADDR_W-1:0] i_mc_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mc_result,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_data,
  output logic                  o_stall_wb,
  input  logic [REG_ADDR_W-1:0] i_chk_addr,
  output logic                  o_chk_pending
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

  // Long-latency handshake: a result transfers on a cycle where i_mc_valid and
  // o_mc_ready are both high; o_mc_ready depends only on registered occupancy.

  wb_entry_t        head;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age_q, age_d;
  logic             head_live, head_drop, forced, pipe_wr;
  logic             head_grant, pop, push;

  // Live heads need the port; killed or x0 heads are discarded without it.
  assign head_live  = head.valid && !head.killed && (head.rd != REG_X0);
  assign head_drop  = head.valid && (head.killed || (head.rd == REG_X0));
  assign forced     = head_live && ((count == CNT_W'(FIFO_DEPTH)) ||
                                    (age_q == AGE_W'(STARVE_MAX)));
  assign pipe_wr    = !forced && i_pipe_we && (i_pipe_rd_addr != REG_X0);
  assign head_grant = head_live && (forced || !pipe_wr);
  assign pop        = head_grant || head_drop;
  assign o_mc_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push       = i_mc_valid && o_mc_ready;
  assign o_stall_wb = forced;

  wb_pending_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (i_clk),
    .rst_ni      (i_arstn),
    .push_i      (push),
    .push_rd_i   (i_mc_rd_addr),
    .push_data_i (i_mc_result),
    .pop_i       (pop),
    .kill_en_i   (pipe_wr),
    .kill_addr_i (i_pipe_rd_addr),
    .chk_addr_i  (i_chk_addr),
    .head_o      (head),
    .count_o     (count),
    .chk_hit_o   (o_chk_pending)
  );

  // Age of the current head: counts refused cycles, restarts for each new head.
  always_comb begin
    age_d = age_q;
    if (pop || !head_live)              age_d = '0;
    else if (age_q != AGE_W'(STARVE_MAX)) age_d = age_q + 1'b1;
  end

  // Age register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) age_q <= '0;
    else          age_q <= age_d;
  end

  // Write-port mux: pipe path is purely combinational, no added latency.
  always_comb begin
    o_rf_we   = 1'b0;
    o_rf_addr = '0;
    o_rf_data = '0;
    if (pipe_wr) begin
      o_rf_we   = 1'b1;
      o_rf_addr = i_pipe_rd_addr;
      o_rf_data = i_pipe_result;
    end else if (head_grant) begin
      o_rf_we   = 1'b1;
      o_rf_addr = head.rd;
      o_rf_data = head.data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic        i_clk;
  logic        i_arstn;
  logic        i_pipe_we;
  logic [4:0]  i_pipe_rd_addr;
  logic [63:0] i_pipe_result;
  logic        i_mc_valid;
  logic        o_mc_ready;
  logic [4:0]  i_mc_rd_addr;
  logic [63:0] i_mc_result;
  logic        o_rf_we;
  logic [4:0]  o_rf_addr;
  logic [63:0] o_rf_data;
  logic        o_stall_wb;
  logic [4:0]  i_chk_addr;
  logic        o_chk_pending;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter dut (
    .i_clk          (i_clk),
    .i_arstn        (i_arstn),
    .i_pipe_we      (i_pipe_we),
    .i_pipe_rd_addr (i_pipe_rd_addr),
    .i_pipe_result  (i_pipe_result),
    .i_mc_valid     (i_mc_valid),
    .o_mc_ready     (o_mc_ready),
    .i_mc_rd_addr   (i_mc_rd_addr),
    .i_mc_result    (i_mc_result),
    .o_rf_we        (o_rf_we),
    .o_rf_addr      (o_rf_addr),
    .o_rf_data      (o_rf_data),
    .o_stall_wb     (o_stall_wb),
    .i_chk_addr     (i_chk_addr),
    .o_chk_pending  (o_chk_pending)
  );

  // Clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_pipe_we = 1'b0; i_pipe_rd_addr = '0; i_pipe_result = '0;
    i_mc_valid = 1'b0; i_mc_rd_addr = '0; i_mc_result = '0;
    i_chk_addr = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [63:0] d);
    i_pipe_we = 1'b1; i_pipe_rd_addr = a; i_pipe_result = d;
  endtask

  task automatic mc(input logic [4:0] a, input logic [63:0] d);
    i_mc_valid = 1'b1; i_mc_rd_addr = a; i_mc_result = d;
  endtask

  task automatic test_reset();
    i_arstn = 1'b0;
    idle();
    i_chk_addr = 5'd5;
    #2;
    checks++;
    if ({o_rf_we, o_stall_wb, o_mc_ready, o_chk_pending} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0010", {o_rf_we, o_stall_wb, o_mc_ready, o_chk_pending});
    end
    repeat (2) step();
    i_arstn = 1'b1;
    step();
    checks++;
    if ({o_rf_we, o_mc_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release got=%b exp=01", {o_rf_we, o_mc_ready});
    end
  endtask

  task automatic test_idle_drain();
    idle(); mc(5'd5, 64'hA); #1;
    checks++;
    if ({o_rf_we, o_mc_ready} !== 2'b01) begin
      errors++; $display("FAIL drain_c0 got=%b exp=01", {o_rf_we, o_mc_ready});
    end
    step();
    idle(); i_chk_addr = 5'd5; #1;
    checks++;
    if ({o_rf_we, o_rf_addr, o_rf_data, o_chk_pending, o_stall_wb} !== {1'b1, 5'd5, 64'hA, 1'b1, 1'b0}) begin
      errors++; $display("FAIL drain_c1 we=%b addr=%0d data=%h pend=%b stall=%b exp 1/5/a/1/0",
                         o_rf_we, o_rf_addr, o_rf_data, o_chk_pending, o_stall_wb);
    end
    step(); #1;
    checks++;
    if ({o_rf_we, o_chk_pending} !== 2'b00) begin
      errors++; $display("FAIL drain_c2 got=%b exp=00", {o_rf_we, o_chk_pending});
    end
  endtask

  task automatic test_starve();
    idle(); pipe(5'd1, 64'h100); mc(5'd7, 64'h7); #1;
    checks++;
    if ({o_rf_we, o_rf_addr} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL starve_c0 we=%b addr=%0d exp 1/1", o_rf_we, o_rf_addr);
    end
    step();
    i_mc_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      checks++;
      if ({o_stall_wb, o_rf_we, o_rf_addr, o_rf_data} !== {1'b0, 1'b1, 5'd1, 64'h100}) begin
        errors++; $display("FAIL starve_refused cyc=%0d stall=%b addr=%0d data=%h exp 0/1/100",
                           c, o_stall_wb, o_rf_addr, o_rf_data);
      end
      step();
    end
    i_chk_addr = 5'd7; #1;
    checks++;
    if ({o_stall_wb, o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 1'b1, 5'd7, 64'h7}) begin
      errors++; $display("FAIL starve_forced stall=%b we=%b addr=%0d data=%h exp 1/1/7/7",
                         o_stall_wb, o_rf_we, o_rf_addr, o_rf_data);
    end
    step(); #1;
    checks++;
    if ({o_stall_wb, o_rf_addr, o_chk_pending} !== {1'b0, 5'd1, 1'b0}) begin
      errors++; $display("FAIL starve_after stall=%b addr=%0d pend=%b exp 0/1/0",
                         o_stall_wb, o_rf_addr, o_chk_pending);
    end
    idle(); step();
  endtask

  task automatic test_full();
    idle(); pipe(5'd1, 64'h100);
    for (int i = 0; i < 4; i++) begin
      mc(5'(10 + i), 64'h40 + 64'(i)); #1;
      checks++;
      if ({o_mc_ready, o_stall_wb, o_rf_addr} !== {1'b1, 1'b0, 5'd1}) begin
        errors++; $display("FAIL full_push i=%0d ready=%b stall=%b addr=%0d exp 1/0/1",
                           i, o_mc_ready, o_stall_wb, o_rf_addr);
      end
      step();
    end
    mc(5'd14, 64'hEE); #1;
    checks++;
    if ({o_mc_ready, o_stall_wb, o_rf_we, o_rf_addr, o_rf_data} !== {1'b0, 1'b1, 1'b1, 5'd10, 64'h40}) begin
      errors++; $display("FAIL full_forced ready=%b stall=%b we=%b addr=%0d data=%h exp 0/1/1/10/40",
                         o_mc_ready, o_stall_wb, o_rf_we, o_rf_addr, o_rf_data);
    end
    step();
    i_mc_valid = 1'b0; i_chk_addr = 5'd14; #1;
    checks++;
    if ({o_mc_ready, o_stall_wb, o_rf_addr, o_chk_pending} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
      errors++; $display("FAIL full_after ready=%b stall=%b addr=%0d pend14=%b exp 1/0/1/0",
                         o_mc_ready, o_stall_wb, o_rf_addr, o_chk_pending);
    end
    step();
    idle();
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if ({o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 5'(10 + i), 64'h40 + 64'(i)}) begin
        errors++; $display("FAIL full_drain i=%0d we=%b addr=%0d data=%h", i, o_rf_we, o_rf_addr, o_rf_data);
      end
      step();
    end
    #1;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL full_empty we=%b exp 0", o_rf_we);
    end
  endtask

  task automatic test_waw();
    idle(); mc(5'd3, 64'h11); step();
    idle(); pipe(5'd3, 64'h22); i_chk_addr = 5'd3; #1;
    checks++;
    if ({o_rf_we, o_rf_addr, o_rf_data, o_chk_pending} !== {1'b1, 5'd3, 64'h22, 1'b1}) begin
      errors++; $display("FAIL waw_pipe we=%b addr=%0d data=%h pend=%b exp 1/3/22/1",
                         o_rf_we, o_rf_addr, o_rf_data, o_chk_pending);
    end
    step();
    i_pipe_we = 1'b0; #1;
    checks++;
    if ({o_rf_we, o_chk_pending} !== 2'b00) begin
      errors++; $display("FAIL waw_killed got=%b exp=00", {o_rf_we, o_chk_pending});
    end
    step();
    idle(); pipe(5'd4, 64'h44); mc(5'd4, 64'h33); i_chk_addr = 5'd4; #1;
    checks++;
    if ({o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 5'd4, 64'h44}) begin
      errors++; $display("FAIL waw_same we=%b addr=%0d data=%h exp 1/4/44", o_rf_we, o_rf_addr, o_rf_data);
    end
    step();
    i_pipe_we = 1'b0; i_mc_valid = 1'b0; #1;
    checks++;
    if ({o_rf_we, o_chk_pending} !== 2'b00) begin
      errors++; $display("FAIL waw_same_killed got=%b exp=00", {o_rf_we, o_chk_pending});
    end
    step();
  endtask

  task automatic test_x0();
    idle(); mc(5'd0, 64'hFF); step();
    idle(); #1;
    checks++;
    if ({o_rf_we, o_chk_pending} !== 2'b00) begin
      errors++; $display("FAIL x0_entry got=%b exp=00", {o_rf_we, o_chk_pending});
    end
    step();
    pipe(5'd0, 64'h99); mc(5'd6, 64'h66); #1;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_pipe_empty we=%b exp 0", o_rf_we);
    end
    step();
    i_mc_valid = 1'b0; #1;
    checks++;
    if ({o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 5'd6, 64'h66}) begin
      errors++; $display("FAIL x0_pipe_drain we=%b addr=%0d data=%h exp 1/6/66", o_rf_we, o_rf_addr, o_rf_data);
    end
    step(); idle(); #1;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_final we=%b exp 0", o_rf_we);
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 6; i++) begin
      mc(5'(20 + i), 64'h1000 + 64'(i)); #1;
      checks++;
      if (i == 0) begin
        if (o_rf_we !== 1'b0) begin
          errors++; $display("FAIL b2b_first we=%b exp 0", o_rf_we);
        end
      end else if ({o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 5'(19 + i), 64'h1000 + 64'(i - 1)}) begin
        errors++; $display("FAIL b2b i=%0d we=%b addr=%0d data=%h", i, o_rf_we, o_rf_addr, o_rf_data);
      end
      step();
    end
    idle(); #1;
    checks++;
    if ({o_rf_we, o_rf_addr, o_rf_data} !== {1'b1, 5'd25, 64'h1005}) begin
      errors++; $display("FAIL b2b_last we=%b addr=%0d data=%h exp 1/25/1005", o_rf_we, o_rf_addr, o_rf_data);
    end
    step(); #1;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL b2b_empty we=%b exp 0", o_rf_we);
    end
  endtask

  task automatic test_reset_mid();
    idle(); pipe(5'd1, 64'h100); mc(5'd8, 64'h88); step();
    mc(5'd9, 64'h99); step();
    idle(); i_arstn = 1'b0; i_chk_addr = 5'd8; #1;
    checks++;
    if ({o_rf_we, o_mc_ready, o_chk_pending, o_stall_wb} !== 4'b0100) begin
      errors++; $display("FAIL rstmid_assert got=%b exp=0100", {o_rf_we, o_mc_ready, o_chk_pending, o_stall_wb});
    end
    step();
    i_arstn = 1'b1; i_chk_addr = 5'd9; #1;
    checks++;
    if ({o_rf_we, o_chk_pending} !== 2'b00) begin
      errors++; $display("FAIL rstmid_release got=%b exp=00", {o_rf_we, o_chk_pending});
    end
    step(); #1;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_stale we=%b exp 0", o_rf_we);
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_starve();
    test_full();
    test_waw();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order write-back stage and a long-latency functional unit (multiply/divide) that returns results out of band. Late results are buffered in a small FIFO and written back in idle write-port slots. A starved or full buffer forces a one-cycle write-back stall. A pending-destination query is exposed to the hazard unit. Sits between the write-back stage, the long-latency unit and the register file.

## Interface
- DATA_WIDTH, 64, register data width
- REG_ADDR_W, 5, register address width
- FIFO_DEPTH, 4, pending-result entries (power of two, ≥2)
- STARVE_MAX, 8, cycles a buffered head may be refused before a forced grant

- i_clk  in  1  clock; one clock domain, all state on rising edge
- i_arstn  in  1  asynchronous, active-low reset
- i_pipe_we  in  1  write-back stage write enable
- i_pipe_rd_addr  in  REG_ADDR_W  write-back destination
- i_pipe_result  in  DATA_WIDTH  write-back data
- i_mc_valid  in  1  long-latency result valid
- o_mc_ready  out  1  arbiter can accept a result
- i_mc_rd_addr  in  REG_ADDR_W  long-latency destination
- i_mc_result  in  DATA_WIDTH  long-latency data
- o_rf_we  out  1  register-file write enable
- o_rf_addr  out  REG_ADDR_W  register-file write address
- o_rf_data  out  DATA_WIDTH  register-file write data
- o_stall_wb  out  1  hold write-back stage (its write is ignored this cycle)
- i_chk_addr  in  REG_ADDR_W  hazard-unit query address
- o_chk_pending  out  1  a live buffered write targets i_chk_addr

## Operation
- Entry fields: valid, killed, rd, data. A push occurs when i_mc_valid && o_mc_ready. o_mc_ready = (count < FIFO_DEPTH). There is no same-cycle pop credit.
- Forced mode: asserted when the head is live (valid, not killed) and either count == FIFO_DEPTH or age == STARVE_MAX. In forced mode, o_stall_wb=1, the head is written and popped, and the pipe write is ignored.
- Normal mode:
  - If i_pipe_we && i_pipe_rd_addr != 0, the pipe is written.
  - Otherwise, if the head is live, the head is written and popped.
- A killed head is popped every cycle without using the port, independent of pipe activity.
- Writes to x0 never assert o_rf_we. A live x0 entry is popped without a write.
- WAW kill: when the pipe write is granted, every valid entry with a matching rd sets killed=1. A same-cycle push with a matching rd is also stored killed. Long-latency results are always older than concurrent pipe write-backs.
- Age counter: increments while the head is live and not granted. It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
- o_chk_pending = i_chk_addr != 0 && any entry valid && !killed && rd == i_chk_addr. Results still inside the long-latency unit are not covered; the hazard unit tracks those.
- Simultaneous push and pop: count is unchanged, and the pointers advance with wrap modulo FIFO_DEPTH.

## Timing
- Reset (async assert, sync-safe deassert): count=0, all entries invalid, age=0. The outputs are then o_rf_we=0, o_stall_wb=0, o_mc_ready=1 and o_chk_pending=0. Reset mid-operation discards buffered results.
- o_rf_*: combinational from pipe inputs and FIFO head, with zero added latency on the pipe path.
- A pushed result is writable no earlier than the cycle after acceptance.
- o_stall_wb: combinational from registered state only, with no path from the i_pipe_* inputs.
- o_mc_ready: combinational from registered count only.
- o_chk_pending: combinational from i_chk_addr and state. It reflects kills and pops only after the clock edge.
- Worst-case head wait is STARVE_MAX+1 cycles.

## Structure
- Package wb_arb_pkg holds the wb_entry_t struct (valid, killed, rd, data at default widths) and constant REG_X0 = '0.
- Sub-module wb_pending_fifo provides the storage, pointers, count, a kill-by-address broadcast and a parallel address match for the query.
- wb_port_arbiter holds the grant logic, the age counter and the output muxing.

## Test plan
- Reset mid-operation: with 2 entries buffered, pulse i_arstn low → o_rf_we=0, o_mc_ready=1, o_chk_pending=0 immediately; after release, no stale write occurs.
- Idle drain: push x5=0xA at cycle 0 with the pipe idle → cycle 1 shows o_rf_we=1, addr=5, data=0xA, and o_chk_pending(5) drops at cycle 2.
- Starvation: pipe writes x1 every cycle and x7=0x7 is pushed → after 8 refused cycles, o_stall_wb=1 and the port writes x7=0x7 that cycle; the pipe write is ignored.
- Full: with the pipe busy, push 4 results → o_mc_ready=0. The next cycle forces drains with o_stall_wb=1 until count<4, and o_mc_ready rises the cycle after the first pop.
- WAW kill: push x3=0x11, then the pipe writes x3=0x22 → the register file receives only 0x22. The entry pops without a write and o_chk_pending(3)=0 after the edge.
- x0: push x0=0xFF with the pipe idle → no o_rf_we, count returns to 0; a pipe write to x0 leaves o_rf_we=0 and the buffered head may drain that cycle.
